// File: rtl/rgmii_rx_decode.sv
// rgmii_rx_decode: RGMII rise/fall sample pairs to GMII bytes, with 10/100 nibble assembly,
// in-band status decode and a saturating errored-frame counter.
module rgmii_rx_decode #(
  parameter int ERR_CNT_W = 16,
  parameter bit STATUS_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           rx_q1,
  input  logic [4:0]           rx_q2,
  input  logic [1:0]           speed_i,
  output logic [7:0]           gmii_rxd_o,
  output logic                 gmii_rx_dv_o,
  output logic                 gmii_rx_er_o,
  output logic                 gmii_rx_valid_o,
  output logic                 link_up_o,
  output logic [1:0]           link_speed_o,
  output logic                 full_duplex_o,
  output logic [ERR_CNT_W-1:0] err_count_o
);
  typedef enum logic [1:0] {IDLE, PRE, DATA} state_t;
  state_t state_q, state_d;
  logic phase_q, phase_d, erp_q, erp_d, err_seen_q, err_seen_d, have_q;
  logic [3:0] pend_q, pend_d, last_q;
  logic [1:0] speed_q;
  logic [7:0] rxd_q, rxd_d;
  logic dv_q, dv_d, er_q, er_d, vld_q, vld_d;
  logic link_q, duplex_q;
  logic [1:0] lspeed_q;
  logic [ERR_CNT_W-1:0] cnt_q;
  logic dv, er, gig, ph, qual, upd, inc;
  logic [3:0] nib;

  assign dv = rx_q1[4];
  assign er = rx_q1[4] ^ rx_q2[4];
  assign nib = rx_q1[3:0];
  // speed_i only steers decoding while idle; mid-frame the latched copy rules
  assign gig = (state_q == IDLE) ? speed_i[1] : speed_q[1];
  assign ph = (state_q != IDLE) && phase_q;
  assign qual = !rx_q1[4] && !rx_q2[4] && (nib == rx_q2[3:0]);
  assign upd = STATUS_EN && qual && have_q && (last_q == nib);
  assign inc = vld_d && dv_d && er_d && !err_seen_q;
  assign err_seen_d = dv && (err_seen_q || inc);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pend_d = pend_q;
    erp_d = erp_q;
    vld_d = 1'b0;
    rxd_d = rxd_q;
    dv_d = dv_q;
    er_d = er_q;
    if (gig) begin
      {vld_d, rxd_d, dv_d, er_d} = {1'b1, rx_q2[3:0], nib, dv, er};
      state_d = dv ? DATA : IDLE;
      phase_d = 1'b0;
    end else if (!dv) begin
      state_d = IDLE;
      phase_d = 1'b0;
      if (ph)
        {vld_d, rxd_d, dv_d, er_d} = {1'b1, 4'h0, pend_q, 1'b1, 1'b1};
      else if (state_q == IDLE && er) begin
        phase_d = !phase_q;
        if (phase_q) {vld_d, rxd_d, dv_d, er_d} = {1'b1, nib, nib, 1'b0, 1'b1};
      end
    end else if (state_q != DATA) begin
      // the first dv cycle out of IDLE is already a preamble nibble
      state_d = PRE;
      if (nib == 4'h5) begin
        phase_d = !ph;
        if (ph) {vld_d, rxd_d, dv_d, er_d} = {1'b1, 8'h55, 1'b1, er | erp_q};
        else {pend_d, erp_d} = {nib, er};
      end else begin
        state_d = DATA;
        phase_d = 1'b0;
        {vld_d, rxd_d, dv_d, er_d} = (nib == 4'hD) ? {1'b1, 8'hD5, 1'b1, er} : {1'b1, nib, pend_q, 1'b1, 1'b1};
      end
    end else begin
      phase_d = !phase_q;
      if (phase_q) {vld_d, rxd_d, dv_d, er_d} = {1'b1, nib, pend_q, 1'b1, er | erp_q};
      else {pend_d, erp_d} = {nib, er};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      {phase_q, erp_q, err_seen_q, have_q, pend_q, last_q, speed_q} <= '0;
      {rxd_q, dv_q, er_q, vld_q} <= '0;
      {link_q, lspeed_q, duplex_q} <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pend_q <= pend_d;
      erp_q <= erp_d;
      err_seen_q <= err_seen_d;
      speed_q <= (state_q == IDLE) ? speed_i : speed_q;
      {rxd_q, dv_q, er_q, vld_q} <= {rxd_d, dv_d, er_d, vld_d};
      cnt_q <= (inc && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
      have_q <= qual;
      last_q <= nib;
      if (upd) {link_q, lspeed_q, duplex_q} <= {nib[0], nib[2:1], nib[3]};
    end
  end

  assign gmii_rxd_o = rxd_q;
  assign gmii_rx_dv_o = dv_q;
  assign gmii_rx_er_o = er_q;
  assign gmii_rx_valid_o = vld_q;
  assign link_up_o = link_q;
  assign link_speed_o = lspeed_q;
  assign full_duplex_o = duplex_q;
  assign err_count_o = cnt_q;
endmodule

// File: tb/tb_rgmii_rx_decode.sv
// tb_rgmii_rx_decode: directed scenario tasks for rgmii_rx_decode with hand-computed expectations.
module tb_rgmii_rx_decode;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0] rx_q1 = '0;
  logic [4:0] rx_q2 = '0;
  logic [1:0] speed_i = 2'b10;
  logic [7:0] gmii_rxd_o;
  logic gmii_rx_dv_o, gmii_rx_er_o, gmii_rx_valid_o, link_up_o, full_duplex_o;
  logic [1:0] link_speed_o;
  logic [2:0] err_count_o;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  rgmii_rx_decode #(.ERR_CNT_W(3), .STATUS_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .rx_q1(rx_q1), .rx_q2(rx_q2), .speed_i(speed_i),
    .gmii_rxd_o(gmii_rxd_o), .gmii_rx_dv_o(gmii_rx_dv_o), .gmii_rx_er_o(gmii_rx_er_o),
    .gmii_rx_valid_o(gmii_rx_valid_o), .link_up_o(link_up_o), .link_speed_o(link_speed_o),
    .full_duplex_o(full_duplex_o), .err_count_o(err_count_o)
  );

  task automatic step(input logic [4:0] a, input logic [4:0] b);
    rx_q1 = a;
    rx_q2 = b;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({gmii_rxd_o, gmii_rx_dv_o, gmii_rx_er_o, gmii_rx_valid_o} !== 11'h0) begin
      miscompares++;
      $display("FAIL reset_data: got %h expected 000", {gmii_rxd_o, gmii_rx_dv_o, gmii_rx_er_o, gmii_rx_valid_o});
    end
    vectors++;
    if ({link_up_o, link_speed_o, full_duplex_o, err_count_o} !== 7'h0) begin
      miscompares++;
      $display("FAIL reset_status: got %h expected 00", {link_up_o, link_speed_o, full_duplex_o, err_count_o});
    end
    rst = 1'b0;
  endtask

  task automatic test_gig_frame;
    logic [7:0] b [12];
    b = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'h12, 8'h34, 8'hAB, 8'hF0};
    speed_i = 2'b10;
    step(5'h00, 5'h00);
    for (int i = 0; i < 12; i++) begin
      step({1'b1, b[i][3:0]}, {1'b1, b[i][7:4]});
      vectors++;
      if ({gmii_rxd_o, gmii_rx_dv_o, gmii_rx_er_o, gmii_rx_valid_o} !== {b[i], 3'b101}) begin
        miscompares++;
        $display("FAIL gig_byte%0d: got %h/%b%b%b expected %h/101", i, gmii_rxd_o, gmii_rx_dv_o, gmii_rx_er_o, gmii_rx_valid_o, b[i]);
      end
    end
    step(5'h00, 5'h00);
    vectors++;
    if ({gmii_rx_dv_o, gmii_rx_er_o, gmii_rx_valid_o} !== 3'b001) begin
      miscompares++;
      $display("FAIL gig_idle: got dv/er/vld %b%b%b expected 001", gmii_rx_dv_o, gmii_rx_er_o, gmii_rx_valid_o);
    end
  endtask

  task automatic test_100m_frame;
    logic [3:0] n [20];
    logic [7:0] e [10];
    int k;
    n = '{4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5,
          4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'hD, 4'h1, 4'h2, 4'h3, 4'h4};
    e = '{8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'hD5, 8'h21, 8'h43};
    k = 0;
    speed_i = 2'b01;
    step(5'h00, 5'h00);
    for (int i = 0; i < 21; i++) begin
      if (i < 20) step({1'b1, n[i]}, {1'b1, n[i]});
      else step(5'h00, 5'h00);
      vectors++;
      if (gmii_rx_valid_o !== ((i == 15 || i % 2 == 1) && i < 20)) begin
        miscompares++;
        $display("FAIL m100_valid%0d: got %b expected %b", i, gmii_rx_valid_o, ((i == 15 || i % 2 == 1) && i < 20));
      end
      if (gmii_rx_valid_o === 1'b1 && k < 10) begin
        vectors++;
        if ({gmii_rxd_o, gmii_rx_dv_o, gmii_rx_er_o} !== {e[k], 2'b10}) begin
          miscompares++;
          $display("FAIL m100_byte%0d: got %h/%b%b expected %h/10", k, gmii_rxd_o, gmii_rx_dv_o, gmii_rx_er_o, e[k]);
        end
        k++;
      end
    end
    vectors++;
    if (err_count_o !== 3'd0) begin
      miscompares++;
      $display("FAIL m100_errcnt: got %0d expected 0", err_count_o);
    end
  endtask

  task automatic test_10m_truncation;
    logic [3:0] n [6];
    logic [9:0] e [4];
    logic [6:0] vp;
    int k;
    n = '{4'h5, 4'h5, 4'hD, 4'hA, 4'hB, 4'hC};
    e = '{{8'h55, 2'b10}, {8'hD5, 2'b10}, {8'hBA, 2'b10}, {8'h0C, 2'b11}};
    vp = 7'b1010110;
    k = 0;
    speed_i = 2'b00;
    step(5'h00, 5'h00);
    for (int i = 0; i < 7; i++) begin
      if (i < 6) step({1'b1, n[i]}, {1'b1, n[i]});
      else step(5'h00, 5'h00);
      vectors++;
      if (gmii_rx_valid_o !== vp[i]) begin
        miscompares++;
        $display("FAIL m10_valid%0d: got %b expected %b", i, gmii_rx_valid_o, vp[i]);
      end
      if (gmii_rx_valid_o === 1'b1 && k < 4) begin
        vectors++;
        if ({gmii_rxd_o, gmii_rx_dv_o, gmii_rx_er_o} !== e[k]) begin
          miscompares++;
          $display("FAIL m10_byte%0d: got %h expected %h", k, {gmii_rxd_o, gmii_rx_dv_o, gmii_rx_er_o}, e[k]);
        end
        k++;
      end
    end
    vectors++;
    if (err_count_o !== 3'd1) begin
      miscompares++;
      $display("FAIL m10_errcnt: got %0d expected 1", err_count_o);
    end
  endtask

  task automatic test_false_carrier;
    speed_i = 2'b00;
    step(5'h00, 5'h00);
    for (int i = 0; i < 4; i++) begin
      step(5'h0F, 5'h1F);
      vectors++;
      if ({gmii_rx_valid_o, gmii_rxd_o, gmii_rx_dv_o, gmii_rx_er_o} !== ((i % 2 == 1) ? 11'h7FD : {1'b0, gmii_rxd_o, gmii_rx_dv_o, gmii_rx_er_o})) begin
        miscompares++;
        $display("FAIL false_carrier%0d: got %h vld %b", i, {gmii_rxd_o, gmii_rx_dv_o, gmii_rx_er_o}, gmii_rx_valid_o);
      end
    end
    step(5'h00, 5'h00);
    vectors++;
    if (err_count_o !== 3'd1) begin
      miscompares++;
      $display("FAIL false_carrier_errcnt: got %0d expected 1", err_count_o);
    end
  endtask

  task automatic test_gig_error;
    logic [7:0] b [6];
    logic [5:0] ef;
    b = '{8'h55, 8'hD5, 8'h01, 8'h02, 8'h03, 8'h04};
    ef = 6'b011010;
    speed_i = 2'b10;
    step(5'h00, 5'h00);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) speed_i = 2'b00;
      step({1'b1, b[i][3:0]}, {!ef[i], b[i][7:4]});
      vectors++;
      if ({gmii_rxd_o, gmii_rx_dv_o, gmii_rx_er_o, gmii_rx_valid_o} !== {b[i], 1'b1, ef[i], 1'b1}) begin
        miscompares++;
        $display("FAIL gig_err_byte%0d: got %h/%b%b%b expected %h/1%b1", i, gmii_rxd_o, gmii_rx_dv_o, gmii_rx_er_o, gmii_rx_valid_o, b[i], ef[i]);
      end
    end
    speed_i = 2'b10;
    step(5'h00, 5'h00);
    vectors++;
    if (err_count_o !== 3'd2) begin
      miscompares++;
      $display("FAIL gig_err_count: got %0d expected 2", err_count_o);
    end
  endtask

  task automatic test_inband;
    step(5'h00, 5'h00);
    step(5'h00, 5'h00);
    step(5'h0D, 5'h0D);
    vectors++;
    if ({link_up_o, link_speed_o, full_duplex_o} !== 4'b0000) begin
      miscompares++;
      $display("FAIL inband_after_d: got %b expected 0000", {link_up_o, link_speed_o, full_duplex_o});
    end
    step(5'h05, 5'h05);
    vectors++;
    if ({link_up_o, link_speed_o, full_duplex_o} !== 4'b0000) begin
      miscompares++;
      $display("FAIL inband_first5: got %b expected 0000", {link_up_o, link_speed_o, full_duplex_o});
    end
    step(5'h05, 5'h05);
    vectors++;
    if ({link_up_o, link_speed_o, full_duplex_o} !== 4'b1100) begin
      miscompares++;
      $display("FAIL inband_second5: got %b expected 1100", {link_up_o, link_speed_o, full_duplex_o});
    end
    step(5'h0A, 5'h0A);
    step(5'h0A, 5'h03);
    step(5'h0A, 5'h0A);
    vectors++;
    if ({link_up_o, link_speed_o, full_duplex_o} !== 4'b1100) begin
      miscompares++;
      $display("FAIL inband_broken_match: got %b expected 1100", {link_up_o, link_speed_o, full_duplex_o});
    end
    step(5'h0A, 5'h0A);
    vectors++;
    if ({link_up_o, link_speed_o, full_duplex_o} !== 4'b0011) begin
      miscompares++;
      $display("FAIL inband_a: got %b expected 0011", {link_up_o, link_speed_o, full_duplex_o});
    end
  endtask

  task automatic test_reset_midframe;
    logic [3:0] n [5];
    logic [5:0] vp;
    logic [7:0] e [3];
    int k;
    n = '{4'h5, 4'h5, 4'hD, 4'h6, 4'h7};
    vp = 6'b010110;
    e = '{8'h55, 8'hD5, 8'h76};
    k = 0;
    speed_i = 2'b00;
    step(5'h00, 5'h00);
    step(5'h15, 5'h15);
    step(5'h15, 5'h15);
    step(5'h1D, 5'h1D);
    step(5'h11, 5'h11);
    rst = 1'b1;
    step(5'h12, 5'h12);
    vectors++;
    if ({gmii_rxd_o, gmii_rx_dv_o, gmii_rx_er_o, gmii_rx_valid_o, link_up_o, link_speed_o, full_duplex_o, err_count_o} !== 18'h0) begin
      miscompares++;
      $display("FAIL midframe_reset: got %h expected 00000", {gmii_rxd_o, gmii_rx_dv_o, gmii_rx_er_o, gmii_rx_valid_o, link_up_o, link_speed_o, full_duplex_o, err_count_o});
    end
    rst = 1'b0;
    step(5'h00, 5'h00);
    vectors++;
    if (gmii_rx_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL midframe_no_partial: got valid %b expected 0", gmii_rx_valid_o);
    end
    for (int i = 0; i < 6; i++) begin
      if (i < 5) step({1'b1, n[i]}, {1'b1, n[i]});
      else step(5'h00, 5'h00);
      vectors++;
      if (gmii_rx_valid_o !== vp[i]) begin
        miscompares++;
        $display("FAIL post_reset_valid%0d: got %b expected %b", i, gmii_rx_valid_o, vp[i]);
      end
      if (gmii_rx_valid_o === 1'b1 && k < 3) begin
        vectors++;
        if ({gmii_rxd_o, gmii_rx_dv_o, gmii_rx_er_o} !== {e[k], 2'b10}) begin
          miscompares++;
          $display("FAIL post_reset_byte%0d: got %h/%b%b expected %h/10", k, gmii_rxd_o, gmii_rx_dv_o, gmii_rx_er_o, e[k]);
        end
        k++;
      end
    end
  endtask

  task automatic test_err_saturation;
    speed_i = 2'b10;
    step(5'h00, 5'h00);
    for (int f = 1; f <= 9; f++) begin
      step(5'h15, 5'h05);
      step(5'h15, 5'h15);
      step(5'h00, 5'h00);
      vectors++;
      if (err_count_o !== ((f < 7) ? 3'(f) : 3'd7)) begin
        miscompares++;
        $display("FAIL err_sat_frame%0d: got %0d expected %0d", f, err_count_o, (f < 7) ? f : 7);
      end
    end
  endtask

  initial begin
    test_reset;
    test_gig_frame;
    test_100m_frame;
    test_10m_truncation;
    test_false_carrier;
    test_gig_error;
    test_inband;
    test_reset_midframe;
    test_err_saturation;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
